// File: rtl/tick_countdown.sv
// Tick-driven countdown timer: IDLE -> RUN -> EXPIRED with a one-cycle done pulse.
// Optional macro TICK_COUNTDOWN_AUTO_RELOAD_EN turns the terminal tick into a periodic reload.
module tick_countdown #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             timer_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_next;
  logic [WIDTH-1:0] remaining_q;
  logic             load_zero;
  logic             terminal_tick;

  assign load_zero     = (load_value == '0);
  assign terminal_tick = tick && (remaining_q == WIDTH'(1));

`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic             wrap_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic; stop outranks start, start outranks tick
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_next = load_zero ? ST_EXPIRED : ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (start) begin
          state_next = load_zero ? ST_EXPIRED : ST_RUN;
        end else if (terminal_tick) begin
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
          state_next = ST_RUN;
`else
          state_next = ST_EXPIRED;
`endif
        end
      end
      ST_EXPIRED: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Countdown datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_q <= '0;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
      reload_q    <= '0;
      wrap_q      <= 1'b0;
`endif
    end else begin
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
      wrap_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            remaining_q <= load_value;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
            reload_q    <= load_value;
`endif
          end
        end
        ST_RUN: begin
          if (stop) begin
            remaining_q <= '0;
          end else if (start) begin
            remaining_q <= load_value;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
            reload_q    <= load_value;
`endif
          end else if (terminal_tick) begin
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
            remaining_q <= reload_q;
            wrap_q      <= 1'b1;
`else
            remaining_q <= '0;
`endif
          end else if (tick && (remaining_q != '0)) begin
            remaining_q <= remaining_q - WIDTH'(1);
          end
        end
        default: begin
          remaining_q <= remaining_q;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy      = 1'b0;
    timer_en  = 1'b0;
    done      = 1'b0;
    remaining = remaining_q;
    case (state_q)
      ST_RUN: begin
        busy     = 1'b1;
        timer_en = 1'b1;
      end
      ST_EXPIRED: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
    if (wrap_q) begin
      done = 1'b1;
    end
`endif
  end

endmodule
